// File: rtl/alu_input_loader_pkg.sv
// alu_input_loader_pkg: loader FSM states and ALU opcodes shared by loader, ALU and benches
package alu_input_loader_pkg;
  typedef enum logic [1:0] {
    S_A     = 2'b00,
    S_B     = 2'b01,
    S_OP    = 2'b10,
    S_READY = 2'b11
  } state_t;
  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SRL = 6'b000010;
  localparam logic [5:0] OP_NOR = 6'b100111;
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchronizer, debouncer and rising-edge detector for one push-button
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_pulse
);
  localparam int NB_CNT = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'(DEBOUNCE_CYCLES - 1);
  logic [1:0]        r_sync;
  logic [NB_CNT-1:0] r_cnt;
  logic              r_level;
  logic              r_level_d;
  // the level flips on the DEBOUNCE_CYCLES-th consecutive differing cycle
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync    <= '0;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
    end else begin
      r_sync    <= {r_sync[0], i_btn};
      r_level_d <= r_level;
      if (r_sync[1] == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_cnt   <= '0;
        r_level <= ~r_level;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end
  assign o_pulse = r_level & ~r_level_d;
endmodule

// File: rtl/alu_input_loader.sv
// alu_input_loader: loads ALU operands A, B and opcode from switches via debounced buttons in order
module alu_input_loader
  import alu_input_loader_pkg::*;
#(
  parameter int NB_DATA         = 8,
  parameter int NB_OP           = 6,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NB_DATA-1:0] i_sw,
  input  logic               i_btn_a,
  input  logic               i_btn_b,
  input  logic               i_btn_op,
  output logic [NB_DATA-1:0] o_dato_a,
  output logic [NB_DATA-1:0] o_dato_b,
  output logic [NB_OP-1:0]   o_op,
  output logic               o_valid,
  output logic [1:0]         o_state
);
  state_t             r_state;
  state_t             w_next;
  logic [NB_DATA-1:0] r_dato_a;
  logic [NB_DATA-1:0] r_dato_b;
  logic [NB_OP-1:0]   r_op;
  logic               r_valid;
  logic               w_pulse_a;
  logic               w_pulse_b;
  logic               w_pulse_op;
  logic               w_load_a;
  logic               w_load_b;
  logic               w_load_op;
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_a (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_btn(i_btn_a), .o_pulse(w_pulse_a)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_b (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_btn(i_btn_b), .o_pulse(w_pulse_b)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_op (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_btn(i_btn_op), .o_pulse(w_pulse_op)
  );
  // only the pulse the current state waits for can act
  always_comb begin
    w_next    = r_state;
    w_load_a  = 1'b0;
    w_load_b  = 1'b0;
    w_load_op = 1'b0;
    case (r_state)
      S_A, S_READY: if (w_pulse_a) begin
        w_load_a = 1'b1;
        w_next   = S_B;
      end
      S_B: if (w_pulse_b) begin
        w_load_b = 1'b1;
        w_next   = S_OP;
      end
      S_OP: if (w_pulse_op) begin
        w_load_op = 1'b1;
        w_next    = S_READY;
      end
      default: w_next = S_A;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= S_A;
      r_valid  <= 1'b0;
      r_dato_a <= '0;
      r_dato_b <= '0;
      r_op     <= '0;
    end else begin
      r_state <= w_next;
      r_valid <= (w_next == S_READY);
      if (w_load_a) r_dato_a <= i_sw;
      if (w_load_b) r_dato_b <= i_sw;
      if (w_load_op) r_op <= i_sw[NB_OP-1:0];
    end
  end
  assign o_dato_a = r_dato_a;
  assign o_dato_b = r_dato_b;
  assign o_op     = r_op;
  assign o_valid  = r_valid;
  assign o_state  = r_state;
endmodule

// File: doc/alu_input_loader.md
ALU_INPUT_LOADER -- requirements
Module: alu_input_loader

Interface
REQ-001 Parameter NB_DATA, default 8: width of switch bus and of o_dato_a / o_dato_b.
REQ-002 Parameter NB_OP, default 6: width of o_op, taken from i_sw[NB_OP-1:0].
REQ-003 Parameter DEBOUNCE_CYCLES, default 1_000_000: consecutive stable cycles required to accept a button level change; legal range 2..2^24-1.
REQ-004 i_clk  input  1  single system clock; all state updates on its rising edge.
REQ-005 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-006 i_sw  input  NB_DATA  raw slide-switch value, asynchronous to i_clk.
REQ-007 i_btn_a / i_btn_b / i_btn_op  input  1 each  raw push-buttons, asynchronous, active-high.
REQ-008 o_dato_a / o_dato_b  output  NB_DATA each  registered operands for the downstream ALU.
REQ-009 o_op  output  NB_OP  registered opcode for the downstream ALU.
REQ-010 o_valid  output  1  high while all three registers hold a complete load sequence.
REQ-011 o_state  output  2  current FSM state encoding, for LED display.

Function
REQ-012 Each button SHALL pass through a 2-flop synchronizer, then a debouncer, then a rising-edge detector producing a one-cycle load pulse.
REQ-013 Debouncer SHALL count cycles where synchronized input differs from debounced level, clear the count when equal, and toggle the level when the count reaches DEBOUNCE_CYCLES.
REQ-014 Load pulse SHALL be high exactly one cycle, the first cycle the debounced level is high; a held button SHALL produce no further pulses.
REQ-015 Target register SHALL capture i_sw on the edge ending the pulse cycle, i.e. on rising edge DEBOUNCE_CYCLES+3, counting the first edge that samples the raw button high as edge 1.
REQ-016 Glitches shorter than DEBOUNCE_CYCLES synchronized cycles SHALL produce no pulse and no register change.
REQ-017 FSM states: S_A=2'b00, S_B=2'b01, S_OP=2'b10, S_READY=2'b11; o_state SHALL equal the current state.
REQ-018 S_A: pulse_a loads o_dato_a, next S_B; other pulses ignored.
REQ-019 S_B: pulse_b loads o_dato_b, next S_OP; other pulses ignored.
REQ-020 S_OP: pulse_op loads o_op from i_sw[NB_OP-1:0], next S_READY; other pulses ignored.
REQ-021 S_READY: pulse_a loads o_dato_a, next S_B; pulse_b and pulse_op ignored.
REQ-022 Simultaneous pulses SHALL be resolved by state: only the pulse expected by the current state acts.
REQ-023 o_valid SHALL be registered and high exactly while in S_READY.
REQ-024 Outputs SHALL hold their last value in every state except on their own load edge; no register is cleared by state changes.
REQ-025 o_op values are passed unmodified; opcode legality is the ALU's concern.

Reset
REQ-026 While i_rst_n is low: o_dato_a, o_dato_b, o_op = 0; o_valid = 0; state = S_A; synchronizers, debounce counters, debounced levels and edge registers = 0.
REQ-027 Assertion SHALL take effect immediately without a clock edge; deassertion is synchronized externally to i_clk.
REQ-028 A button held through reset release SHALL generate a pulse once debounced, as a fresh press.

Structure
REQ-029 State encodings and the ALU opcode localparams (ADD 6'b100000, SUB 6'b100010, AND 6'b100100, OR 6'b100101, XOR 6'b100110, SRA 6'b000011, SRL 6'b000010, NOR 6'b100111) SHALL live in a shared package/include used by loader, ALU and benches.
REQ-030 Synchronizer + debouncer + edge detector SHALL be one sub-module, btn_debounce (params DEBOUNCE_CYCLES), instantiated three times.
REQ-031 Debounce counter width SHALL be $clog2(DEBOUNCE_CYCLES+1).

Verification (DEBOUNCE_CYCLES=4)
REQ-032 Reset: assert i_rst_n=0 mid-operation -> all outputs 0, o_state=00 immediately, o_valid=0.
REQ-033 Full sequence: i_sw=8'h2A press A; 8'h05 press B; 8'h20 press OP (each held 10 cycles) -> o_dato_a=8'h2A, o_dato_b=8'h05, o_op=6'b100000, o_valid=1, o_state=11; each update on edge 7 after press.
REQ-034 Glitch: i_btn_a high 3 cycles in S_A -> no change, o_state=00.
REQ-035 Out-of-order: in S_A press OP and B with i_sw=8'hFF -> all registers unchanged, o_state=00.
REQ-036 Held button: i_btn_a high 100 cycles -> exactly one pulse, one load, state S_B only.
REQ-037 Reload: from S_READY press A with i_sw=8'h81 -> o_dato_a=8'h81, o_dato_b/o_op unchanged, o_valid falls same edge, o_state=01.
